// File: rtl/trash_loader.sv
// Program loader: buffers PROG_BYTES program bytes, pulses the core reset, bursts
// them as programming words, then forwards execution instructions in RUN.
module trash_loader #(
  parameter int          PROG_BYTES = 8,
  parameter logic [15:0] IDLE_WORD  = 16'h0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        b_valid,
  input  logic [7:0]  b_data,
  output logic        b_ready,
  input  logic        i_valid,
  input  logic [14:0] i_data,
  output logic        i_ready,
  output logic [15:0] word_out,
  output logic        core_rst_n,
  output logic        busy,
  output logic        done
);
  localparam int CW = $clog2(PROG_BYTES);
  localparam logic [CW-1:0] LAST = CW'(PROG_BYTES - 1);

  typedef enum logic [2:0] {IDLE, FILL, CRST, BURST, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] nxt;
  logic [7:0]    mem [PROG_BYTES];
  logic          run_q;
  logic          b_beat;
  logic          i_beat;

  assign nxt    = cnt + CW'(1);
  assign b_beat = b_valid & b_ready;
  // stop must refuse a same-cycle instruction, so the registered enable is
  // masked by stop; this is the only output with a combinational term.
  assign i_ready = run_q & ~stop;
  assign i_beat  = i_valid & i_ready;

  // Image buffer needs no reset: a reset discards the image by clearing cnt/state.
  always_ff @(posedge clk) begin
    if (b_beat) mem[cnt] <= b_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      run_q      <= 1'b0;
      b_ready    <= 1'b0;
      word_out   <= IDLE_WORD;
      core_rst_n <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          word_out <= IDLE_WORD;
          if (start) begin
            state   <= FILL;
            cnt     <= '0;
            b_ready <= 1'b1;
            busy    <= 1'b1;
          end
        end
        FILL: begin
          if (b_beat) begin
            if (cnt == LAST) begin
              state      <= CRST;
              cnt        <= '0;
              b_ready    <= 1'b0;
              core_rst_n <= 1'b0;
            end else begin
              cnt <= nxt;
            end
          end
        end
        CRST: begin
          state      <= BURST;
          cnt        <= '0;
          core_rst_n <= 1'b1;
          word_out   <= {mem[0], 8'h00};
        end
        BURST: begin
          if (cnt == LAST) begin
            state    <= RUN;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
            run_q    <= 1'b1;
            word_out <= IDLE_WORD;
          end else begin
            cnt      <= nxt;
            word_out <= {mem[nxt], 8'h00};
          end
        end
        RUN: begin
          if (stop) begin
            state    <= IDLE;
            run_q    <= 1'b0;
            word_out <= IDLE_WORD;
          end else if (i_beat) begin
            word_out <= {i_data, 1'b1};
          end else begin
            word_out <= IDLE_WORD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_trash_loader.sv
// Directed bench for trash_loader: load, burst, run stream, stop, reset, stray start.
module tb_trash_loader;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, b_valid, i_valid;
  logic [7:0]  b_data;
  logic [14:0] i_data;
  logic        b_ready, i_ready, core_rst_n, busy, done;
  logic [15:0] word_out;
  int total = 0;
  int bad   = 0;

  trash_loader #(.PROG_BYTES(8), .IDLE_WORD(16'h0001)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .i_valid(i_valid), .i_data(i_data), .i_ready(i_ready),
    .word_out(word_out), .core_rst_n(core_rst_n), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; stop = 0; b_valid = 0; b_data = 0; i_valid = 0; i_data = 0;
    #12;
    total++; if ({word_out, core_rst_n, b_ready, i_ready, busy, done} !== {16'h0001, 5'b10000}) begin
      bad++; $display("FAIL reset_outs got=%h/%b%b%b%b%b exp=0001/10000", word_out, core_rst_n, b_ready, i_ready, busy, done);
    end
    rst_n = 1'b1;
    tick(); tick();
    total++; if ({busy, b_ready} !== 2'b00) begin
      bad++; $display("FAIL reset_no_start got=%b%b exp=00", busy, b_ready);
    end
  endtask

  task automatic test_nominal();
    start = 1; tick(); start = 0;
    total++; if ({busy, b_ready, word_out} !== {2'b11, 16'h0001}) begin
      bad++; $display("FAIL nom_fill_entry got=%b%b %h exp=11 0001", busy, b_ready, word_out);
    end
    for (int k = 0; k < 8; k++) begin
      b_valid = 1; b_data = 8'((k + 1) * 8'h11); tick();
      if (k < 7) begin
        total++; if (word_out !== 16'h0001) begin
          bad++; $display("FAIL nom_fill_word k=%0d got=%h exp=0001", k, word_out);
        end
      end
    end
    b_valid = 0;
    total++; if ({core_rst_n, b_ready, word_out} !== {2'b00, 16'h0001}) begin
      bad++; $display("FAIL nom_crst got=%b%b %h exp=00 0001", core_rst_n, b_ready, word_out);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      total++; if ({core_rst_n, word_out} !== {1'b1, 8'((k + 1) * 8'h11), 8'h00}) begin
        bad++; $display("FAIL nom_burst k=%0d got=%b %h exp=1 %h00", k, core_rst_n, word_out, 8'((k + 1) * 8'h11));
      end
    end
    tick();
    total++; if ({done, busy, i_ready, word_out} !== {3'b101, 16'h0001}) begin
      bad++; $display("FAIL nom_run_entry got=%b%b%b %h exp=101 0001", done, busy, i_ready, word_out);
    end
    tick();
    total++; if ({done, word_out} !== {1'b0, 16'h0001}) begin
      bad++; $display("FAIL nom_done_pulse got=%b %h exp=0 0001", done, word_out);
    end
  endtask

  task automatic test_run_stream();
    i_valid = 1; i_data = 15'h0009; tick(); i_valid = 0;
    total++; if (word_out !== 16'h0013) begin
      bad++; $display("FAIL run_w0 got=%h exp=0013", word_out);
    end
    tick();
    total++; if (word_out !== 16'h0001) begin
      bad++; $display("FAIL run_gap got=%h exp=0001", word_out);
    end
    i_valid = 1; i_data = 15'h1A03; tick(); i_valid = 0;
    total++; if (word_out !== 16'h3407) begin
      bad++; $display("FAIL run_w1 got=%h exp=3407", word_out);
    end
    tick();
    total++; if (word_out !== 16'h0001) begin
      bad++; $display("FAIL run_idle got=%h exp=0001", word_out);
    end
  endtask

  task automatic test_stop_collision();
    stop = 1; i_valid = 1; i_data = 15'h7FFF; #1;
    total++; if (i_ready !== 1'b0) begin
      bad++; $display("FAIL stop_iready got=%b exp=0", i_ready);
    end
    tick(); stop = 0; i_valid = 0;
    total++; if ({word_out, i_ready, busy} !== {16'h0001, 2'b00}) begin
      bad++; $display("FAIL stop_idle got=%h %b%b exp=0001 00", word_out, i_ready, busy);
    end
    stop = 1; tick(); stop = 0; tick();
    total++; if ({b_ready, busy, word_out} !== {2'b00, 16'h0001}) begin
      bad++; $display("FAIL stop_stays_idle got=%b%b %h exp=00 0001", b_ready, busy, word_out);
    end
  endtask

  task automatic test_stalled_fill();
    start = 1; tick(); start = 0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        b_valid = 0;
        for (int g = 0; g < 3; g++) begin
          tick();
          total++; if ({b_ready, core_rst_n, word_out} !== {2'b11, 16'h0001}) begin
            bad++; $display("FAIL stall_gap k=%0d got=%b%b %h exp=11 0001", k, b_ready, core_rst_n, word_out);
          end
        end
      end
      b_valid = 1; b_data = 8'((k + 1) * 8'h11); tick();
    end
    b_valid = 0;
    total++; if (core_rst_n !== 1'b0) begin
      bad++; $display("FAIL stall_crst got=%b exp=0", core_rst_n);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      total++; if (word_out !== {8'((k + 1) * 8'h11), 8'h00}) begin
        bad++; $display("FAIL stall_burst k=%0d got=%h exp=%h00", k, word_out, 8'((k + 1) * 8'h11));
      end
    end
    tick();
    total++; if (done !== 1'b1) begin
      bad++; $display("FAIL stall_done got=%b exp=1", done);
    end
    stop = 1; tick(); stop = 0;
  endtask

  task automatic test_reset_mid_burst();
    start = 1; tick(); start = 0;
    for (int k = 0; k < 8; k++) begin
      b_valid = 1; b_data = 8'((k + 1) * 8'h11); tick();
    end
    b_valid = 0;
    for (int k = 0; k < 3; k++) tick();
    total++; if (word_out !== 16'h3300) begin
      bad++; $display("FAIL rmb_pre got=%h exp=3300", word_out);
    end
    #2 rst_n = 0; #1;
    total++; if ({word_out, core_rst_n, busy, b_ready} !== {16'h0001, 3'b100}) begin
      bad++; $display("FAIL rmb_async got=%h %b%b%b exp=0001 100", word_out, core_rst_n, busy, b_ready);
    end
    #3 rst_n = 1;
    tick(); tick();
    total++; if ({busy, b_ready, word_out} !== {2'b00, 16'h0001}) begin
      bad++; $display("FAIL rmb_idle got=%b%b %h exp=00 0001", busy, b_ready, word_out);
    end
  endtask

  task automatic test_start_ignored();
    start = 1; tick(); start = 0;
    for (int k = 0; k < 8; k++) begin
      b_valid = 1; b_data = 8'hA0 + 8'(k); tick();
      if (k == 6) begin
        total++; if ({b_ready, core_rst_n} !== 2'b11) begin
          bad++; $display("FAIL fresh_7bytes got=%b%b exp=11", b_ready, core_rst_n);
        end
      end
    end
    b_valid = 0;
    for (int k = 0; k < 8; k++) begin
      start = (k % 2 == 0); tick();
      total++; if (word_out !== {8'hA0 + 8'(k), 8'h00}) begin
        bad++; $display("FAIL ign_burst k=%0d got=%h exp=%h00", k, word_out, 8'hA0 + 8'(k));
      end
    end
    start = 1; tick();
    total++; if ({done, busy, i_ready, word_out} !== {3'b101, 16'h0001}) begin
      bad++; $display("FAIL ign_run_entry got=%b%b%b %h exp=101 0001", done, busy, i_ready, word_out);
    end
    tick(); start = 0;
    total++; if ({busy, b_ready, i_ready, word_out} !== {3'b001, 16'h0001}) begin
      bad++; $display("FAIL ign_run got=%b%b%b %h exp=001 0001", busy, b_ready, i_ready, word_out);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_run_stream();
    test_stop_collision();
    test_stalled_fill();
    test_reset_mid_burst();
    test_start_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
